// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the retire trace path: record layout, field offsets,
// FIFO occupancy states and a record builder.
package cpu_trace_pkg;

   localparam int RETIRE_W     = 70;
   localparam int RT_PC_LSB    = 0;
   localparam int RT_WDATA_LSB = 32;
   localparam int RT_WADDR_LSB = 64;
   localparam int RT_EN_BIT    = 69;

   typedef struct packed {
      logic        en;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
   } retire_rec_t;

   typedef enum logic [1:0] {
      FIFO_EMPTY,
      FIFO_PARTIAL,
      FIFO_FULL
   } fifo_state_t;

   function automatic retire_rec_t make_rec(input logic [4:0]  waddr,
                                            input logic [31:0] wdata,
                                            input logic [31:0] pc);
      logic [RETIRE_W-1:0] v;
      v                        = '0;
      v[RT_EN_BIT]             = 1'b1;
      v[RT_WADDR_LSB +: 5]     = waddr;
      v[RT_WDATA_LSB +: 32]    = wdata;
      v[RT_PC_LSB +: 32]       = pc;
      return retire_rec_t'(v);
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with valid/ready pop, exact occupancy count and full flag.
// The head holds the last popped word while empty, so output data never glitches to stale slots.
module trace_fifo
   import cpu_trace_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = RETIRE_W,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count,
   output logic             o_full
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_last;
   fifo_state_t      r_state;
   fifo_state_t      w_state_nxt;
   logic             w_pop;
   logic             w_write;

   assign o_valid = (r_state != FIFO_EMPTY);
   assign o_full  = (r_state == FIFO_FULL);
   assign o_count = r_count;
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : r_last;
   assign w_pop   = o_valid & i_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_write = i_push & (!o_full | w_pop);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FIFO_EMPTY: begin
            if (w_write) w_state_nxt = FIFO_PARTIAL;
         end
         FIFO_PARTIAL: begin
            if (w_write && !w_pop && r_count == CW'(DEPTH - 1))
               w_state_nxt = FIFO_FULL;
            else if (w_pop && !w_write && r_count == CW'(1))
               w_state_nxt = FIFO_EMPTY;
         end
         FIFO_FULL: begin
            if (w_pop && !w_write) w_state_nxt = FIFO_PARTIAL;
         end
         default: w_state_nxt = FIFO_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= FIFO_EMPTY;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_last   <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_write) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_last   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_write && !w_pop)
            r_count <= r_count + CW'(1);
         else if (w_pop && !w_write)
            r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: rtl/retire_trace_unit.sv
// Tracks the in-flight PC, forms the registered retire record, counts retirements
// and drops, flags multiple writebacks, and buffers records in the trace FIFO.
module retire_trace_unit
   import cpu_trace_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        inst_accept,
   input  logic [31:0]                 inst_pc,
   input  logic                        inst_done,
   input  logic                        rf_wen,
   input  logic [4:0]                  rf_waddr,
   input  logic [31:0]                 rf_wdata,
   output logic [RETIRE_W-1:0]         inst_retire,
   output logic                        trace_valid,
   input  logic                        trace_ready,
   output logic [RETIRE_W-1:0]         trace_data,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [CNT_W-1:0]            retired_cnt,
   output logic [CNT_W-1:0]            drop_cnt,
   output logic                        multi_wb_err
);

   logic [31:0]    r_cur_pc;
   retire_rec_t    r_rec;
   logic           r_push;
   logic           r_wb_seen;
   logic           r_multi;
   logic [CNT_W-1:0] r_retired;
   logic [CNT_W-1:0] r_drop;
   logic           w_fifo_full;
   logic           w_drop;

   assign inst_retire  = r_rec;
   assign retired_cnt  = r_retired;
   assign drop_cnt     = r_drop;
   assign multi_wb_err = r_multi;
   assign w_drop       = r_push & w_fifo_full & !(trace_valid & trace_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur_pc  <= '0;
         r_rec     <= '0;
         r_push    <= 1'b0;
         r_wb_seen <= 1'b0;
         r_multi   <= 1'b0;
         r_retired <= '0;
         r_drop    <= '0;
      end else begin
         if (inst_accept) r_cur_pc <= inst_pc;
         // A write coinciding with accept belongs to the previous instruction: use the old PC.
         if (rf_wen)
            r_rec <= make_rec(rf_waddr, rf_wdata, r_cur_pc);
         else
            r_rec.en <= 1'b0;
         r_push <= rf_wen;
         if (inst_done)
            r_wb_seen <= 1'b0;
         else if (rf_wen)
            r_wb_seen <= 1'b1;
         if (rf_wen && r_wb_seen) r_multi <= 1'b1;
         if (inst_done) r_retired <= r_retired + CNT_W'(1);
         if (w_drop && r_drop != '1) r_drop <= r_drop + CNT_W'(1);
      end
   end

   trace_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RETIRE_W)
   ) u_trace_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_push),
      .i_data  (r_rec),
      .o_valid (trace_valid),
      .i_ready (trace_ready),
      .o_data  (trace_data),
      .o_count (fifo_count),
      .o_full  (w_fifo_full)
   );

endmodule
